// File: rtl/fifo2serial.sv
// Drains a show-ahead FIFO one word at a time and streams it to a byte UART,
// as raw bytes or uppercase ASCII hex, with an optional trailer byte per word.
//
// state | meaning
// IDLE  | strobe FIFO read when non-empty, latch word on the following edge
// SEND  | wait for uart_ready, then present the current unit
// WAIT  | hold the load strobe until the UART drops uart_ready
// TRAIL | wait for uart_ready, then present the trailer byte
// TWAIT | hold the trailer load strobe until the UART drops uart_ready
module fifo2serial #(
    parameter int          DW         = 48,
    parameter int          HEX        = 0,
    parameter int          TRAILER_EN = 1,
    parameter logic [7:0]  TRAILER    = 8'h0A
) (
    input  logic          clock,
    input  logic          reset,
    output logic          read_clock_enable,
    input  logic [DW-1:0] read_data,
    input  logic          read_empty,
    input  logic          uart_ready,
    output logic [7:0]    uart_data,
    output logic          uart_clock_enable,
    output logic          busy,
    output logic [15:0]   frame_count
);

    localparam int NU = (HEX != 0) ? DW / 4 : DW / 8;
    localparam int IW = (NU > 1) ? $clog2(NU) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NU - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        WAIT  = 3'd2,
        TRAIL = 3'd3,
        TWAIT = 3'd4
    } state_t;

    state_t        state;
    logic [DW-1:0] word;
    logic [IW-1:0] unit_idx;
    logic [7:0]    unit_byte;

    // Unit 0 is the most-significant byte or nibble of the latched word.
    if (HEX != 0) begin : g_hex
        logic [3:0] nibble;
        always_comb begin
            nibble = 4'h0;
            for (int i = 0; i < NU; i++) begin
                if (unit_idx == IW'(i)) nibble = word[DW-1-4*i -: 4];
            end
            unit_byte = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                         : (8'h37 + {4'h0, nibble});
        end
    end else begin : g_raw
        always_comb begin
            unit_byte = 8'h00;
            for (int i = 0; i < NU; i++) begin
                if (unit_idx == IW'(i)) unit_byte = word[DW-1-8*i -: 8];
            end
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            read_clock_enable <= 1'b0;
            uart_clock_enable <= 1'b0;
            uart_data         <= 8'h00;
            busy              <= 1'b0;
            frame_count       <= 16'h0000;
            word              <= '0;
            unit_idx          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A strobe that meets an empty flag is simply withdrawn.
                    if (read_empty) begin
                        read_clock_enable <= 1'b0;
                    end else if (!read_clock_enable) begin
                        read_clock_enable <= 1'b1;
                    end else begin
                        word              <= read_data;
                        read_clock_enable <= 1'b0;
                        unit_idx          <= '0;
                        busy              <= 1'b1;
                        state             <= SEND;
                    end
                end
                SEND: begin
                    if (uart_ready) begin
                        uart_data         <= unit_byte;
                        uart_clock_enable <= 1'b1;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (!uart_ready) begin
                        uart_clock_enable <= 1'b0;
                        if (unit_idx == LAST_IDX) begin
                            if (TRAILER_EN != 0) begin
                                state <= TRAIL;
                            end else begin
                                state       <= IDLE;
                                busy        <= 1'b0;
                                frame_count <= frame_count + 16'd1;
                            end
                        end else begin
                            unit_idx <= unit_idx + 1'b1;
                            state    <= SEND;
                        end
                    end
                end
                TRAIL: begin
                    if (uart_ready) begin
                        uart_data         <= TRAILER;
                        uart_clock_enable <= 1'b1;
                        state             <= TWAIT;
                    end
                end
                TWAIT: begin
                    if (!uart_ready) begin
                        uart_clock_enable <= 1'b0;
                        state             <= IDLE;
                        busy              <= 1'b0;
                        frame_count       <= frame_count + 16'd1;
                    end
                end
                default: begin
                    state             <= IDLE;
                    read_clock_enable <= 1'b0;
                    uart_clock_enable <= 1'b0;
                    busy              <= 1'b0;
                end
            endcase
        end
    end

endmodule
